// File: rtl/fp_sub_result_stage.sv
// Result stage after the subtraction exception checker: tags issued ops, merges the checker
// decision with the arithmetic result, and buffers results. Define FP_SUB_EXC_COUNT_EN for exc_count.
module fp_sub_result_stage #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned SUB_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  exc_sel,
   input  logic [DATA_WIDTH-1:0] exc_out,
   input  logic                  arith_valid,
   input  logic [DATA_WIDTH-1:0] arith_result,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  res_exc,
   input  logic                  clr_sticky,
   output logic                  sticky_exc,
   output logic                  orphan_err
`ifdef FP_SUB_EXC_COUNT_EN
   ,
   output logic [15:0]           exc_count
`endif
);

   localparam int unsigned CREDITS = SUB_LATENCY + 2;
   localparam int unsigned PW      = $clog2(CREDITS);
   localparam int unsigned CW      = $clog2(CREDITS + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t CREDIT_LIMIT = cnt_t'(CREDITS);
   localparam ptr_t LAST_SLOT    = ptr_t'(CREDITS - 1);

   function automatic ptr_t ptr_next(input ptr_t p);
      return (p == LAST_SLOT) ? '0 : p + ptr_t'(1);
   endfunction

   logic                  tag_sel  [CREDITS];
   logic [DATA_WIDTH-1:0] tag_val  [CREDITS];
   ptr_t                  tag_wr;
   ptr_t                  tag_rd;
   cnt_t                  tag_cnt;

   // Result storage spans every credit: the subtractor cannot stall, so each credited op
   // needs a guaranteed slot even while res_ready is held low.
   logic [DATA_WIDTH-1:0] out_data [CREDITS];
   logic                  out_exc  [CREDITS];
   ptr_t                  out_wr;
   ptr_t                  out_rd;
   cnt_t                  out_cnt;

   logic                  issue;
   logic                  complete;
   logic                  orphan;
   logic                  deliver;
   logic                  deliver_exc;
   logic [DATA_WIDTH-1:0] done_data;
   logic                  done_exc;

   always_comb begin
      in_ready    = (tag_cnt + out_cnt) < CREDIT_LIMIT;
      issue       = in_valid && in_ready;
      complete    = arith_valid && (tag_cnt != '0);
      orphan      = arith_valid && (tag_cnt == '0);
      res_valid   = (out_cnt != '0);
      res_data    = res_valid ? out_data[out_rd] : '0;
      res_exc     = res_valid && out_exc[out_rd];
      deliver     = res_valid && res_ready;
      deliver_exc = deliver && res_exc;
      done_data   = tag_sel[tag_rd] ? arith_result : tag_val[tag_rd];
      done_exc    = !tag_sel[tag_rd];
   end

   always_ff @(posedge clk) begin
      if (issue) begin
         tag_sel[tag_wr] <= exc_sel;
         tag_val[tag_wr] <= exc_out;
      end
      if (complete) begin
         out_data[out_wr] <= done_data;
         out_exc[out_wr]  <= done_exc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_wr     <= '0;
         tag_rd     <= '0;
         tag_cnt    <= '0;
         out_wr     <= '0;
         out_rd     <= '0;
         out_cnt    <= '0;
         sticky_exc <= 1'b0;
         orphan_err <= 1'b0;
      end else begin
         if (issue)    tag_wr <= ptr_next(tag_wr);
         if (complete) tag_rd <= ptr_next(tag_rd);
         if (complete) out_wr <= ptr_next(out_wr);
         if (deliver)  out_rd <= ptr_next(out_rd);

         case ({issue, complete})
            2'b10:   tag_cnt <= tag_cnt + cnt_t'(1);
            2'b01:   tag_cnt <= tag_cnt - cnt_t'(1);
            default: ;
         endcase

         case ({complete, deliver})
            2'b10:   out_cnt <= out_cnt + cnt_t'(1);
            2'b01:   out_cnt <= out_cnt - cnt_t'(1);
            default: ;
         endcase

         // Set takes priority over a same-cycle clear.
         if (deliver_exc)     sticky_exc <= 1'b1;
         else if (clr_sticky) sticky_exc <= 1'b0;

         if (orphan)          orphan_err <= 1'b1;
         else if (clr_sticky) orphan_err <= 1'b0;
      end
   end

`ifdef FP_SUB_EXC_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_count <= '0;
      end else if (clr_sticky) begin
         exc_count <= {15'd0, deliver_exc};
      end else if (deliver_exc && (exc_count != '1)) begin
         exc_count <= exc_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_sub_result_stage.sv
// Self-checking bench for fp_sub_result_stage: acts as the fixed-latency subtractor and
// compares the DUT against a queue-based model of tags, results and sticky status.
`timescale 1ns/1ps
module tb_fp_sub_result_stage;

   localparam int CREDITS     = 5;
   localparam int SUB_LATENCY = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        exc_sel = 1'b0;
   logic [31:0] exc_out = '0;
   logic        arith_valid = 1'b0;
   logic [31:0] arith_result = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_exc;
   logic        clr_sticky = 1'b0;
   logic        sticky_exc;
   logic        orphan_err;
`ifdef FP_SUB_EXC_COUNT_EN
   logic [15:0] exc_count;
`endif

   always #5 clk = ~clk;

   fp_sub_result_stage #(
      .DATA_WIDTH  (32),
      .SUB_LATENCY (SUB_LATENCY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .exc_sel      (exc_sel),
      .exc_out      (exc_out),
      .arith_valid  (arith_valid),
      .arith_result (arith_result),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_exc      (res_exc),
      .clr_sticky   (clr_sticky),
      .sticky_exc   (sticky_exc),
      .orphan_err   (orphan_err)
`ifdef FP_SUB_EXC_COUNT_EN
      ,
      .exc_count    (exc_count)
`endif
   );

   typedef struct { logic sel; logic [31:0] val; } tag_t;
   typedef struct { logic [31:0] d; logic e; } res_t;
   typedef struct { int due; logic [31:0] r; } sub_t;

   tag_t        m_tags[$];
   res_t        m_outq[$];
   sub_t        sched[$];
   logic        m_sticky = 1'b0;
   logic        m_orphan = 1'b0;
   logic [15:0] m_cnt = '0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        orphan_req = 1'b0;
   logic [31:0] issue_result = '0;

   logic [36:0] dut_vec;
   assign dut_vec = {in_ready, res_valid, res_data, res_exc, sticky_exc, orphan_err};

   localparam logic [36:0] RESET_VEC = 37'h10_0000_0000;

   function automatic logic [36:0] exp_vec();
      logic [31:0] d;
      logic        e;
      d = '0;
      e = 1'b0;
      if (m_outq.size() > 0) begin
         d = m_outq[0].d;
         e = m_outq[0].e;
      end
      return {((m_tags.size() + m_outq.size()) < CREDITS), (m_outq.size() > 0), d, e,
              m_sticky, m_orphan};
   endfunction

   // One clock: update the model from pre-edge inputs, then drive the subtractor side.
   task automatic tick();
      logic iss, set_s, set_o;
      tag_t t;
      res_t r;
      sub_t s;
      @(posedge clk);
      iss = in_valid && ((m_tags.size() + m_outq.size()) < CREDITS);
      if (rst) begin
         m_tags.delete();
         m_outq.delete();
         m_sticky = 1'b0;
         m_orphan = 1'b0;
         m_cnt    = '0;
      end else begin
         set_s = 1'b0;
         set_o = 1'b0;
         if (res_ready && m_outq.size() > 0) begin
            set_s = m_outq[0].e;
            void'(m_outq.pop_front());
         end
         if (arith_valid) begin
            if (m_tags.size() == 0) set_o = 1'b1;
            else begin
               t   = m_tags.pop_front();
               r.d = t.sel ? arith_result : t.val;
               r.e = !t.sel;
               m_outq.push_back(r);
            end
         end
         if (iss) begin
            t.sel = exc_sel;
            t.val = exc_out;
            m_tags.push_back(t);
            s.due = cyc + SUB_LATENCY;
            s.r   = issue_result;
            sched.push_back(s);
         end
         m_sticky = set_s | (m_sticky & !clr_sticky);
         m_orphan = set_o | (m_orphan & !clr_sticky);
         if (clr_sticky) m_cnt = {15'd0, set_s};
         else if (set_s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      cyc++;
      #1;
      if (sched.size() > 0 && sched[0].due == cyc) begin
         s            = sched.pop_front();
         arith_valid  = 1'b1;
         arith_result = s.r;
      end else if (orphan_req) begin
         arith_valid  = 1'b1;
         arith_result = $urandom;
         orphan_req   = 1'b0;
      end else begin
         arith_valid  = 1'b0;
         arith_result = $urandom;
      end
   endtask

   task automatic drain();
      in_valid   = 1'b0;
      res_ready  = 1'b1;
      clr_sticky = 1'b0;
      for (int i = 0; i < 30 && (sched.size() > 0 || m_outq.size() > 0 || m_tags.size() > 0); i++)
         tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (dut_vec !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", dut_vec, RESET_VEC);
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL reset_idle: got %h expected %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_exception();
      res_ready    = 1'b1;
      in_valid     = 1'b1;
      exc_sel      = 1'b0;
      exc_out      = 32'hFF80_0000;
      issue_result = 32'h1234_5678;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (res_valid !== (k == 4)) begin
            errors++;
            $display("FAIL exc_latency: cycle %0d res_valid got %b expected %b", k, res_valid, (k == 4));
         end
         if (k < 4) tick();
      end
      checks++;
      if ({res_data, res_exc} !== {32'hFF80_0000, 1'b1}) begin
         errors++;
         $display("FAIL exc_data: got %h/%b expected ff800000/1", res_data, res_exc);
      end
      tick();
      checks++;
      if ({sticky_exc, res_valid} !== 2'b10) begin
         errors++;
         $display("FAIL exc_sticky: got sticky %b valid %b expected 1 0", sticky_exc, res_valid);
      end
   endtask

   task automatic test_arith();
      clr_sticky = 1'b1;
      tick();
      clr_sticky   = 1'b0;
      res_ready    = 1'b1;
      in_valid     = 1'b1;
      exc_sel      = 1'b1;
      exc_out      = $urandom;
      issue_result = 32'h3F80_0000;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({res_valid, res_data, res_exc} !== {1'b1, 32'h3F80_0000, 1'b0}) begin
         errors++;
         $display("FAIL arith_data: got v%b %h/%b expected v1 3f800000/0", res_valid, res_data, res_exc);
      end
      tick();
      checks++;
      if (sticky_exc !== 1'b0) begin
         errors++;
         $display("FAIL arith_sticky: got %b expected 0", sticky_exc);
      end
   endtask

   task automatic test_back_pressure();
      res_t exp_q[$];
      int   dut_acc;
      dut_acc   = 0;
      res_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exc_sel      = 1'($urandom);
         exc_out      = $urandom;
         issue_result = $urandom;
         checks++;
         if (in_ready !== (i < 5)) begin
            errors++;
            $display("FAIL bp_in_ready: cycle %0d got %b expected %b", i, in_ready, (i < 5));
         end
         if (in_ready) dut_acc++;
         if ((m_tags.size() + m_outq.size()) < CREDITS)
            exp_q.push_back('{exc_sel ? issue_result : exc_out, !exc_sel});
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (dut_acc != 5) begin
         errors++;
         $display("FAIL bp_accepts: got %0d expected 5", dut_acc);
      end
      res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (res_valid !== (i < 5)) begin
            errors++;
            $display("FAIL bp_drain_valid: slot %0d got %b expected %b", i, res_valid, (i < 5));
         end
         if (i < 5 && i < exp_q.size()) begin
            checks++;
            if ({res_data, res_exc} !== {exp_q[i].d, exp_q[i].e}) begin
               errors++;
               $display("FAIL bp_order: slot %0d got %h/%b expected %h/%b", i, res_data, res_exc,
                        exp_q[i].d, exp_q[i].e);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      res_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         exc_sel      = 1'($urandom);
         exc_out      = $urandom;
         issue_result = $urandom;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready: cycle %0d got %b expected 1", i, in_ready);
         end
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL stream_out: cycle %0d got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_orphan();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      orphan_req = 1'b1;
      tick();
      tick();
      checks++;
      if ({orphan_err, res_valid} !== 2'b10) begin
         errors++;
         $display("FAIL orphan_set: got err %b valid %b expected 1 0", orphan_err, res_valid);
      end
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if (orphan_err !== 1'b0) begin
         errors++;
         $display("FAIL orphan_clear: got %b expected 0", orphan_err);
      end
   endtask

   task automatic test_reset_midflight();
      res_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exc_sel      = 1'($urandom);
         exc_out      = $urandom;
         issue_result = $urandom;
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (dut_vec !== RESET_VEC) begin
         errors++;
         $display("FAIL midreset_outputs: got %h expected %h", dut_vec, RESET_VEC);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if ({orphan_err, res_valid} !== 2'b10 || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL midreset_orphan: got %h expected %h", dut_vec, exp_vec());
      end
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         in_valid     = 1'($urandom);
         exc_sel      = 1'($urandom);
         exc_out      = $urandom;
         issue_result = $urandom;
         res_ready    = ($urandom_range(0, 3) != 0);
         clr_sticky   = ($urandom_range(0, 15) == 0);
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random_out: cycle %0d got %h expected %h", i, dut_vec, exp_vec());
         end
`ifdef FP_SUB_EXC_COUNT_EN
         checks++;
         if (exc_count !== m_cnt) begin
            errors++;
            $display("FAIL random_count: cycle %0d got %0d expected %0d", i, exc_count, m_cnt);
         end
`endif
      end
      in_valid   = 1'b0;
      clr_sticky = 1'b0;
   endtask

   initial begin
      test_reset();
      test_exception();
      drain();
      test_arith();
      drain();
      test_back_pressure();
      drain();
      test_back_to_back();
      drain();
      test_orphan();
      drain();
      test_reset_midflight();
      drain();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
